prime_checker_seq: RTL and testbench

PRIME_CHECKER_SEQ -- requirements
Module: prime_checker_seq

---
 rtl/prime_checker_seq.sv | 112 +++++++++++
 tb/tb_prime_checker_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/prime_checker_seq.sv
// Sequential trial-division primality tester: one divisor per clock, smallest
// divisor (>=2) reported alongside the prime/composite verdict.
module prime_checker_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             is_prime,
    output logic [WIDTH-1:0] factor
);

    // Handshake: start is accepted on any rising edge where busy=0 (state IDLE);
    // N is captured on that same edge only. busy=1 means start is ignored.
    // done is a one-cycle pulse; is_prime/factor hold until the next publish.

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             done_d;
    logic             is_prime_d;
    logic [WIDTH-1:0] factor_d;

    logic [2*WIDTH-1:0] d_sq;
    logic [2*WIDTH-1:0] n_wide;
    logic [WIDTH-1:0]   rem;
    logic               n_small;
    logic               sq_exceeds;
    logic               divides;

    // Square at double width so d*d never overflows; d is never 0 (starts at 2).
    assign d_sq       = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
    assign n_wide     = {{WIDTH{1'b0}}, n_q};
    assign rem        = n_q % d_q;
    assign n_small    = (n_q < WIDTH'(2));
    assign sq_exceeds = (d_sq > n_wide);
    assign divides    = (rem == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            d_q      <= WIDTH'(2);
            done     <= 1'b0;
            is_prime <= 1'b0;
            factor   <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            d_q      <= d_d;
            done     <= done_d;
            is_prime <= is_prime_d;
            factor   <= factor_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        d_d        = d_q;
        done_d     = 1'b0;
        is_prime_d = is_prime;
        factor_d   = factor;

        unique case (state_q)
            IDLE: begin
                // abort is a no-op here, so a simultaneous start still wins
                if (start) begin
                    n_d     = N;
                    d_d     = WIDTH'(2);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (n_small) begin
                    is_prime_d = 1'b0;
                    factor_d   = '0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else if (sq_exceeds) begin
                    is_prime_d = 1'b1;
                    factor_d   = n_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else if (divides) begin
                    is_prime_d = 1'b0;
                    factor_d   = d_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    // sq_exceeds fires before d can reach 2^WIDTH, so no wrap
                    d_d = d_q + WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CHECK);

endmodule

// File: tb/tb_prime_checker_seq.sv
// Directed bench for prime_checker_seq: a 32-bit instance for the main paths
// and an 8-bit instance for the narrow-width extreme.
module tb_prime_checker_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] n_in;
    logic        abort;
    logic        busy;
    logic        done;
    logic        is_prime;
    logic [31:0] factor;

    logic        start8;
    logic [7:0]  n8;
    logic        abort8;
    logic        busy8;
    logic        done8;
    logic        is_prime8;
    logic [7:0]  factor8;

    int checks;
    int errors;

    prime_checker_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .N(n_in), .abort(abort),
        .busy(busy), .done(done), .is_prime(is_prime), .factor(factor)
    );

    prime_checker_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .N(n8), .abort(abort8),
        .busy(busy8), .done(done8), .is_prime(is_prime8), .factor(factor8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one test on the 32-bit instance and check verdict, latency and pulse width.
    task automatic run32(input string tag, input logic [31:0] n, input logic exp_prime,
                         input logic [31:0] exp_factor, input int exp_lat);
        int lat;
        @(negedge clk);
        n_in  = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_in  = $urandom;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 70000) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_prime"}, 32'(is_prime), 32'(exp_prime));
        check({tag, "_factor"}, factor, exp_factor);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        n_in   = '0;
        abort  = 1'b0;
        start8 = 1'b0;
        n8     = '0;
        abort8 = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prime", 32'(is_prime), 32'd0);
        check("rst_factor", factor, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // main function and boundary values
        run32("n7", 32'd7, 1'b1, 32'd7, 2);
        run32("n9", 32'd9, 1'b0, 32'd3, 2);
        run32("n4", 32'd4, 1'b0, 32'd2, 1);
        run32("n20", 32'd20, 1'b0, 32'd2, 1);
        run32("n0", 32'd0, 1'b0, 32'd0, 1);
        run32("n1", 32'd1, 1'b0, 32'd0, 1);
        run32("n2", 32'd2, 1'b1, 32'd2, 1);
        run32("n3", 32'd3, 1'b1, 32'd3, 1);
        run32("n13", 32'd13, 1'b1, 32'd13, 3);
        run32("n49", 32'd49, 1'b0, 32'd7, 6);

        // abort on the 2nd CHECK edge of N=13 keeps the N=9 result
        run32("pre_abort", 32'd9, 1'b0, 32'd3, 2);
        @(negedge clk);
        n_in  = 32'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_prime", 32'(is_prime), 32'd0);
        check("abort_factor", factor, 32'd3);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end

        // start held high: ignored while busy, re-accepted in the done cycle
        @(negedge clk);
        n_in  = 32'd13;
        start = 1'b1;
        @(negedge clk);
        n_in  = 32'd4;
        lat   = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hold_lat", 32'(lat), 32'd3);
        check("hold_prime", 32'(is_prime), 32'd1);
        check("hold_factor", factor, 32'd13);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        @(negedge clk);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_prime", 32'(is_prime), 32'd0);
        check("b2b_factor", factor, 32'd2);

        // reset mid-test after a prime result
        run32("pre_rst", 32'd7, 1'b1, 32'd7, 2);
        @(negedge clk);
        n_in  = 32'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_prime", 32'(is_prime), 32'd0);
        check("mid_rst_factor", factor, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("mid_rst_no_done", 32'(done), 32'd0);
        end
        run32("post_rst", 32'd7, 1'b1, 32'd7, 2);

        // 8-bit extreme: 251 needs divisors 2..16
        @(negedge clk);
        n8     = 8'd251;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("w8_busy", 32'(busy8), 32'd1);
        lat = 0;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("w8_lat", 32'(lat), 32'd15);
        check("w8_prime", 32'(is_prime8), 32'd1);
        check("w8_factor", 32'(factor8), 32'd251);

        // 32-bit extreme: d reaches 65536, d*d = 2^32 needs the wide product
        run32("big", 32'd4294967291, 1'b1, 32'd4294967291, 65535);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
